mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 181 ++++++++++++++++++
 tb/tb_mult_div.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// mult_div: HI/LO multiply/divide unit for the E stage.
// Multiplies (MULT/MULTU) complete 5 edges after acceptance and divides
// (DIV/DIVU) complete 10 edges after acceptance. MTHI/MTLO write in a single edge.
// Optional feature: define MD_MADD_EN to enable md_op=111 (MADD). MADD
// accumulates signed A*B into {hi,lo} with a 5-cycle latency. When the macro
// is undefined, code 111 behaves like 000.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | not busy; start accepted, MTHI/MTLO write here
// S_MUL  | multiply/MADD in flight, counter running
// S_DIV  | divide in flight, counter running
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

`ifdef MD_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        madd_req;
    logic        long_req;
    logic [63:0] prod_s, prod_u, mul_res;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div;
    logic [31:0] q_mag, r_mag, quot, rem;

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Request decode: which codes start a multi-cycle operation
    always_comb begin
        madd_req = MADD_EN && (md_op == OP_MADD);
        long_req = start && ((md_op == OP_MULT) || (md_op == OP_MULTU) ||
                             (md_op == OP_DIV)  || (md_op == OP_DIVU)  || madd_req);
        stall_md = md_use_D && (busy || long_req);
    end

    // Result datapath from the latched operands; consumed only at completion
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        mul_res = prod_u;
        case (op_q)
            OP_MULT:  mul_res = prod_s;
`ifdef MD_MADD_EN
            OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
`endif
            default:  mul_res = prod_u;
        endcase

        // Signed divide via magnitudes keeps 0x80000000 / -1 well defined
        a_neg = (op_q == OP_DIV) && a_q[31];
        b_neg = (op_q == OP_DIV) && b_q[31];
        a_mag = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag = b_neg ? (~b_q + 32'd1) : b_q;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state: accept requests when idle, count down while busy, write at completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (state_q == S_IDLE) begin
            if (start) begin
                case (md_op)
                    OP_MULT, OP_MULTU: begin
                        state_d = S_MUL;
                        cnt_d   = MUL_CYCLES;
                        op_d    = md_op;
                        a_d     = A;
                        b_d     = B;
                    end
                    OP_DIV, OP_DIVU: begin
                        state_d = S_DIV;
                        cnt_d   = DIV_CYCLES;
                        op_d    = md_op;
                        a_d     = A;
                        b_d     = B;
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
                    OP_MADD: begin
                        if (madd_req) begin
                            state_d = S_MUL;
                            cnt_d   = MUL_CYCLES;
                            op_d    = md_op;
                            a_d     = A;
                            b_d     = B;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            if (cnt_q <= 4'd1) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                if (state_q == S_MUL) begin
                    hi_d = mul_res[63:32];
                    lo_d = mul_res[31:0];
                end else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Testbench for mult_div: directed and random operations checked against a
// longint arithmetic model of HI/LO.
module tb_mult_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

`ifdef MD_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    mult_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .md_use_D (md_use_D),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural effect of one accepted operation, from the ISA definition
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, pu, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin pu = ua * ub; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
            3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            3'd4: if (b != 0) begin pu = ua / ub; acc = ua % ub; exp_lo = pu[31:0]; exp_hi = acc[31:0]; end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            3'd7: if (MADD_ON) begin
                acc = {exp_hi, exp_lo};
                acc = acc + longint'(sa * sb);
                exp_hi = acc[63:32];
                exp_lo = acc[31:0];
            end
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        if (op == 3'd7 && MADD_ON) return 5;
        return 0;
    endfunction

    // Issue one op at the current negedge, follow it to completion, check latency and HI/LO
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        int lat;
        lat = latency(op);
        md_op = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 30) begin
            n_checks++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                n_fail++;
                $display("FAIL %s hold: hi/lo=%h/%h while busy, required %h/%h", name, hi, lo, exp_hi, exp_lo);
            end
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != lat) begin
            n_fail++;
            $display("FAIL %s latency: busy %0d cycles, required %0d", name, cnt, lat);
        end
        model_op(op, a, b);
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: hi/lo=%h/%h, required %h/%h", name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0; md_use_D = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", busy); end
        n_checks++;
        if (hi !== 32'd0) begin n_fail++; $display("FAIL reset hi: got %h, required 0", hi); end
        n_checks++;
        if (lo !== 32'd0) begin n_fail++; $display("FAIL reset lo: got %h, required 0", lo); end
        n_checks++;
        if (stall_md !== 1'b0) begin n_fail++; $display("FAIL reset stall_md: got %b, required 0", stall_md); end
        reset = 1'b1; md_use_D = 1'b0;
        exp_hi = 0; exp_lo = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            n_fail++; $display("FAIL mult_const: hi/lo=%h/%h, required ffffffff/fffffffa", hi, lo);
        end
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3);
        n_checks++;
        if (hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin
            n_fail++; $display("FAIL multu_const: hi/lo=%h/%h, required 00000002/fffffffa", hi, lo);
        end
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_const: hi/lo=%h/%h, required ffffffff/fffffffd", hi, lo);
        end
        run_op("divu_zero", 3'd4, 32'd7, 32'd0);
        run_op("div_zero", 3'd3, 32'h8000_0000, 32'd0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            n_fail++; $display("FAIL div_ovf_const: hi/lo=%h/%h, required 00000000/80000000", hi, lo);
        end
        run_op("none", 3'd0, 32'h1111_1111, 32'h2222_2222);
    endtask

    task automatic test_mthi();
        run_op("mtlo", 3'd6, 32'hCAFE_F00D, 32'd0);
        run_op("mthi", 3'd5, 32'h1234_5678, 32'd0);
        n_checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D || busy !== 1'b0) begin
            n_fail++; $display("FAIL mthi_const: hi/lo/busy=%h/%h/%b, required 12345678/cafef00d/0", hi, lo, busy);
        end
    endtask

    task automatic test_stall();
        int cnt;
        md_use_D = 1'b1;
        md_op = 3'd1; A = 32'd5; B = 32'hFFFF_FFF9; start = 1'b1;
        #1;
        n_checks++;
        if (stall_md !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b, required 1", stall_md); end
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 30) begin
            n_checks++;
            if (stall_md !== 1'b1) begin n_fail++; $display("FAIL stall_busy: cycle %0d got %b, required 1", cnt, stall_md); end
            cnt++;
            if (cnt == 2) begin start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd3; end
            else begin start = 1'b0; md_op = 3'd0; end
            @(negedge clk);
        end
        start = 1'b0; md_op = 3'd0;
        model_op(3'd1, 32'd5, 32'hFFFF_FFF9);
        n_checks++;
        if (cnt != 5) begin n_fail++; $display("FAIL stall_latency: busy %0d cycles, required 5", cnt); end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL ignored_start: hi/lo=%h/%h, required %h/%h", hi, lo, exp_hi, exp_lo);
        end
        n_checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0) begin
            n_fail++; $display("FAIL after_ignored: busy/stall=%b/%b, required 0/0", busy, stall_md);
        end
        md_use_D = 1'b0;
        md_op = 3'd4; A = 32'd1000; B = 32'd7; start = 1'b1;
        #1;
        n_checks++;
        if (stall_md !== 1'b0) begin n_fail++; $display("FAIL nouse_start: got %b, required 0", stall_md); end
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 30) begin
            n_checks++;
            if (stall_md !== 1'b0) begin n_fail++; $display("FAIL nouse_busy: got %b, required 0", stall_md); end
            cnt++;
            @(negedge clk);
        end
        model_op(3'd4, 32'd1000, 32'd7);
        n_checks++;
        if (cnt != 10 || hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL nouse_divu: cycles %0d hi/lo=%h/%h, required 10 %h/%h", cnt, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 6));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            run_op("random", op, a, b);
        end
    endtask

    task automatic test_reset_abort();
        md_use_D = 1'b1;
        md_op = 3'd3; A = 32'd99; B = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_hi = 0; exp_lo = 0;
        n_checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: busy/stall=%b/%b, required 0/0", busy, stall_md);
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL abort_hilo: hi/lo=%h/%h, required 0/0", hi, lo);
        end
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL abort_late: busy/hi/lo=%b/%h/%h, required 0/0/0", busy, hi, lo);
        end
        md_use_D = 1'b0;
    endtask

    task automatic test_op7();
        run_op("mthi0", 3'd5, 32'd0, 32'd0);
        run_op("mtlo1", 3'd6, 32'd1, 32'd0);
        md_use_D = 1'b1;
        md_op = 3'd7; start = 1'b1; A = 32'd2; B = 32'd2;
        #1;
        n_checks++;
        if (stall_md !== MADD_ON) begin n_fail++; $display("FAIL op7_stall: got %b, required %b", stall_md, MADD_ON); end
        start = 1'b0; md_op = 3'd0;
        md_use_D = 1'b0;
        run_op("op7", 3'd7, 32'd2, 32'd2);
        n_checks++;
        if (hi !== 32'd0 || lo !== (MADD_ON ? 32'd5 : 32'd1)) begin
            n_fail++; $display("FAIL op7_const: hi/lo=%h/%h, required 0/%0d", hi, lo, MADD_ON ? 5 : 1);
        end
        run_op("op7_neg", 3'd7, 32'hFFFF_FFFD, 32'd7);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_hi = 0;
        exp_lo = 0;
        test_reset();
        test_directed();
        test_mthi();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_op7();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
